// File: rtl/qwi_axil2reg.sv
// ----------------------------------------------------------------------------
// qwi_axil2reg : AXI4-Lite slave to single-cycle register strobe bus bridge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qwi_axil2reg #(
  parameter int REGCNT = 2,
  parameter int AWID   = 11,
  parameter int DWID   = 32,
  parameter int RD_LAT = 1
) (
  input  logic              reg_clk,
  input  logic              reg_rst,
  input  logic [AWID+1:0]   s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DWID-1:0]   s_wdata,
  input  logic [DWID/8-1:0] s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [AWID+1:0]   s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [DWID-1:0]   s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              reg_ce,
  output logic [DWID/8-1:0] reg_we,
  output logic [AWID-1:0]   reg_addr,
  output logic [DWID-1:0]   reg_wrd,
  input  logic [DWID-1:0]   reg_rdd
);

  localparam logic [1:0]    c_OKAY   = 2'b00;
  localparam logic [1:0]    c_SLVERR = 2'b10;
  localparam logic [AWID:0] c_REGCNT = (AWID+1)'(REGCNT);
  localparam logic [2:0]    c_RD_LAT = 3'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ACC  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ACC  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RD_RESP = 3'd5
  } state_t;

  state_t                state_q;
  logic                  prefer_wr_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DWID-1:0]       rdata_q;
  logic                  rd_err_q;
  logic [2:0]            cnt_q;
  logic                  reg_ce_q;
  logic [DWID/8-1:0]     reg_we_q;
  logic [AWID-1:0]       reg_addr_q;
  logic [DWID-1:0]       reg_wrd_q;

  logic                  w_wr_cand;
  logic                  w_rd_cand;
  logic [AWID-1:0]       w_aw_idx;
  logic [AWID-1:0]       w_ar_idx;
  logic                  w_aw_ok;
  logic                  w_ar_ok;
  logic                  w_unused_lsbs;

  assign w_wr_cand     = s_awvalid & s_wvalid;
  assign w_rd_cand     = s_arvalid;
  assign w_aw_idx      = s_awaddr[AWID+1:2];
  assign w_ar_idx      = s_araddr[AWID+1:2];
  assign w_aw_ok       = ({1'b0, w_aw_idx} < c_REGCNT);
  assign w_ar_ok       = ({1'b0, w_ar_idx} < c_REGCNT);
  // Byte offset within the word is irrelevant on a word-wide register bus.
  assign w_unused_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      state_q     <= S_IDLE;
      prefer_wr_q <= 1'b1;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= c_OKAY;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= c_OKAY;
      rdata_q     <= '0;
      rd_err_q    <= 1'b0;
      cnt_q       <= 3'd0;
      reg_ce_q    <= 1'b0;
      reg_we_q    <= '0;
      reg_addr_q  <= '0;
      reg_wrd_q   <= '0;
    end else begin
      reg_ce_q   <= 1'b0;
      reg_we_q   <= '0;
      reg_addr_q <= '0;
      reg_wrd_q  <= '0;
      case (state_q)
        S_IDLE: begin
          // Round robin only matters when both request types are pending.
          if (w_wr_cand && (!w_rd_cand || prefer_wr_q)) begin
            state_q     <= S_WR_ACC;
            awready_q   <= 1'b1;
            wready_q    <= 1'b1;
            prefer_wr_q <= 1'b0;
          end else if (w_rd_cand) begin
            state_q     <= S_RD_ACC;
            arready_q   <= 1'b1;
            prefer_wr_q <= 1'b1;
          end
        end
        S_WR_ACC: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          state_q   <= S_WR_RESP;
          bresp_q   <= w_aw_ok ? c_OKAY : c_SLVERR;
          if (w_aw_ok && (s_wstrb != '0)) begin
            reg_ce_q   <= 1'b1;
            reg_we_q   <= s_wstrb;
            reg_addr_q <= w_aw_idx;
            reg_wrd_q  <= s_wdata;
          end
        end
        S_WR_RESP: begin
          if (!bvalid_q) begin
            bvalid_q <= 1'b1;
          end else if (s_bready) begin
            bvalid_q <= 1'b0;
            bresp_q  <= c_OKAY;
            state_q  <= S_IDLE;
          end
        end
        S_RD_ACC: begin
          arready_q <= 1'b0;
          rd_err_q  <= !w_ar_ok;
          cnt_q     <= 3'd0;
          state_q   <= S_RD_WAIT;
          if (w_ar_ok) begin
            reg_ce_q   <= 1'b1;
            reg_addr_q <= w_ar_idx;
          end
        end
        S_RD_WAIT: begin
          // cnt_q is 0 in the strobe cycle, so reg_rdd is sampled RD_LAT cycles later.
          if (cnt_q == c_RD_LAT) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_err_q ? '0 : reg_rdd;
            rresp_q  <= rd_err_q ? c_SLVERR : c_OKAY;
            state_q  <= S_RD_RESP;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        S_RD_RESP: begin
          if (s_rready) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= c_OKAY;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign reg_ce    = reg_ce_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wrd   = reg_wrd_q;

endmodule

`default_nettype wire

// File: tb/tb_qwi_axil2reg.sv
// ----------------------------------------------------------------------------
// tb_qwi_axil2reg : directed vector bench for qwi_axil2reg (RD_LAT 1 and 3)
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_qwi_axil2reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [12:0] awaddr = '0;  logic awvalid = 1'b0; logic awready;
  logic [31:0] wdata  = '0;  logic [3:0] wstrb = '0; logic wvalid = 1'b0; logic wready;
  logic [1:0]  bresp;        logic bvalid;         logic bready = 1'b0;
  logic [12:0] araddr = '0;  logic arvalid = 1'b0; logic arready;
  logic [31:0] rdata;        logic [1:0] rresp;    logic rvalid; logic rready = 1'b0;
  logic        reg_ce;       logic [3:0] reg_we;   logic [10:0] reg_addr;
  logic [31:0] reg_wrd;      logic [31:0] reg_rdd;

  logic [12:0] ar3addr = '0; logic ar3valid = 1'b0; logic ar3ready;
  logic [31:0] rdata3;       logic [1:0] rresp3;    logic rvalid3; logic rready3 = 1'b0;
  logic        awready3, wready3, bvalid3;          logic [1:0] bresp3;
  logic        ce3;          logic [3:0] we3;       logic [10:0] addr3;
  logic [31:0] wrd3;         logic [31:0] rdd3;

  qwi_axil2reg #(.REGCNT(2), .AWID(11), .DWID(32), .RD_LAT(1)) u_dut (
    .reg_clk(clk), .reg_rst(rst),
    .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready),
    .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid), .s_wready(wready),
    .s_bresp(bresp), .s_bvalid(bvalid), .s_bready(bready),
    .s_araddr(araddr), .s_arvalid(arvalid), .s_arready(arready),
    .s_rdata(rdata), .s_rresp(rresp), .s_rvalid(rvalid), .s_rready(rready),
    .reg_ce(reg_ce), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wrd(reg_wrd), .reg_rdd(reg_rdd)
  );

  qwi_axil2reg #(.REGCNT(2), .AWID(11), .DWID(32), .RD_LAT(3)) u_dut3 (
    .reg_clk(clk), .reg_rst(rst),
    .s_awaddr(13'h0), .s_awvalid(1'b0), .s_awready(awready3),
    .s_wdata(32'h0), .s_wstrb(4'h0), .s_wvalid(1'b0), .s_wready(wready3),
    .s_bresp(bresp3), .s_bvalid(bvalid3), .s_bready(1'b0),
    .s_araddr(ar3addr), .s_arvalid(ar3valid), .s_arready(ar3ready),
    .s_rdata(rdata3), .s_rresp(rresp3), .s_rvalid(rvalid3), .s_rready(rready3),
    .reg_ce(ce3), .reg_we(we3), .reg_addr(addr3),
    .reg_wrd(wrd3), .reg_rdd(rdd3)
  );

  // Register file models: data is valid only in the one cycle RD_LAT after the strobe.
  logic [31:0] mem1 [0:1];
  logic [31:0] mem3 [0:1];
  logic [31:0] st3  [0:2];
  always @(posedge clk) begin
    reg_rdd <= 32'hDEAD_BEEF;
    if (reg_ce && reg_addr < 11'd2) begin
      if (reg_we == 4'h0) reg_rdd <= mem1[reg_addr[0]];
      for (int b = 0; b < 4; b++)
        if (reg_we[b]) mem1[reg_addr[0]][8*b +: 8] <= reg_wrd[8*b +: 8];
    end
    st3[0] <= (ce3 && we3 == 4'h0 && addr3 < 11'd2) ? mem3[addr3[0]] : 32'hDEAD_BEEF;
    st3[1] <= st3[0];
    st3[2] <= st3[1];
  end
  assign rdd3 = st3[2];

  int ce_cnt = 0, ce3_cnt = 0, idle_bad = 0;
  logic [3:0]  last_we;
  logic [10:0] last_addr;
  logic [31:0] last_wrd;
  bit          order_q [$];
  always @(negedge clk) begin
    if (reg_ce) begin
      ce_cnt    <= ce_cnt + 1;
      last_we   <= reg_we;
      last_addr <= reg_addr;
      last_wrd  <= reg_wrd;
      order_q.push_back(reg_we != 4'h0);
    end else if (reg_we != 4'h0 || reg_addr != 11'h0 || reg_wrd != 32'h0) begin
      idle_bad <= idle_bad + 1;
    end
    if (ce3) ce3_cnt <= ce3_cnt + 1;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] outs1();
    return {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
            reg_ce, reg_we, reg_addr, reg_wrd};
  endfunction

  task automatic axi_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit to);
    bit ok;
    to = 0; resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; break; end
    end
    if (!ok) to = 1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; resp = bresp; break; end
    end
    if (!ok) to = 1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [12:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output bit to);
    bit ok;
    to = 0; resp = 2'bxx; d = 'x;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) to = 1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; resp = rresp; d = rdata; break; end
    end
    if (!ok) to = 1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          exp_ce;
    logic [3:0]  exp_we;
    logic [10:0] exp_addr;
    logic [31:0] exp_wrd;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp, r1, r2, r3, r4;
    logic [31:0] d, d1, d2;
    bit          to, t1, t2, t3, t4, ok;
    int          c0, n0, bad;
    logic [3:0]  ord;

    vecs[0]  = '{1'b1, 13'h0004, 32'h0000_0003, 4'hF, 1'b1, 4'hF, 11'd1, 32'h0000_0003, 2'b00, 32'h0};
    vecs[1]  = '{1'b1, 13'h0000, 32'h0102_0304, 4'hF, 1'b1, 4'hF, 11'd0, 32'h0102_0304, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 13'h0000, 32'h0,         4'h0, 1'b1, 4'h0, 11'd0, 32'h0,         2'b00, 32'h0102_0304};
    vecs[3]  = '{1'b0, 13'h0004, 32'h0,         4'h0, 1'b1, 4'h0, 11'd1, 32'h0,         2'b00, 32'h0000_0003};
    vecs[4]  = '{1'b1, 13'h0008, 32'h1234_5678, 4'hF, 1'b0, 4'h0, 11'd0, 32'h0,         2'b10, 32'h0};
    vecs[5]  = '{1'b0, 13'h000C, 32'h0,         4'h0, 1'b0, 4'h0, 11'd0, 32'h0,         2'b10, 32'h0};
    vecs[6]  = '{1'b1, 13'h0006, 32'hAABB_CCDD, 4'h5, 1'b1, 4'h5, 11'd1, 32'hAABB_CCDD, 2'b00, 32'h0};
    vecs[7]  = '{1'b0, 13'h0007, 32'h0,         4'h0, 1'b1, 4'h0, 11'd1, 32'h0,         2'b00, 32'h00BB_00DD};
    vecs[8]  = '{1'b1, 13'h0000, 32'hFFFF_FFFF, 4'h0, 1'b0, 4'h0, 11'd0, 32'h0,         2'b00, 32'h0};
    vecs[9]  = '{1'b0, 13'h0000, 32'h0,         4'h0, 1'b1, 4'h0, 11'd0, 32'h0,         2'b00, 32'h0102_0304};
    vecs[10] = '{1'b0, 13'h1FFC, 32'h0,         4'h0, 1'b0, 4'h0, 11'd0, 32'h0,         2'b10, 32'h0};

    mem3[0] = 32'h0102_0304;
    mem3[1] = 32'h0A0B_0C0D;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", outs1(), '0);

    for (int i = 0; i < 11; i++) begin
      c0 = ce_cnt;
      if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, resp, to);
      else               axi_read(vecs[i].addr, d, resp, to);
      chk($sformatf("v%0d_timeout", i), to, 1'b0);
      chk($sformatf("v%0d_ce_count", i), ce_cnt - c0, vecs[i].exp_ce ? 1 : 0);
      if (vecs[i].exp_ce) begin
        chk($sformatf("v%0d_we", i), last_we, vecs[i].exp_we);
        chk($sformatf("v%0d_addr", i), last_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_wrd", i), last_wrd, vecs[i].exp_wrd);
      end
      chk($sformatf("v%0d_resp", i), resp, vecs[i].exp_resp);
      if (!vecs[i].is_wr) chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
    end

    // RD_LAT=3 instance: the model data is only valid in the exact capture cycle.
    c0 = ce3_cnt;
    ar3addr = 13'h0; ar3valid = 1'b1; rready3 = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ar3ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    ar3valid = 1'b0;
    for (int i = 0; i < 50 && ok; i++) begin
      @(negedge clk);
      if (rvalid3) break;
    end
    chk("lat3_rvalid", rvalid3 & ok, 1'b1);
    chk("lat3_rdata", rdata3, 32'h0102_0304);
    chk("lat3_rresp", rresp3, 2'b00);
    chk("lat3_ce_count", ce3_cnt - c0, 1);
    @(posedge clk); #1;
    rready3 = 1'b0;

    // Write response back-pressure with a read waiting behind it.
    awaddr = 13'h4; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 13'h4; arvalid = 1'b1; rready = 1'b1;
    bad = 0;
    for (int i = 0; i < 50 && ok; i++) begin
      @(negedge clk);
      if (arready) bad++;
      if (bvalid) break;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bvalid || bresp != 2'b00 || arready) bad++;
    end
    chk("bhold_handshake", ok & bvalid, 1'b1);
    chk("bhold_stable_cycles_bad", bad, 0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int i = 0; i < 50 && ok; i++) begin
      @(negedge clk);
      if (rvalid) break;
    end
    chk("bhold_read_rvalid", rvalid & ok, 1'b1);
    chk("bhold_read_rdata", rdata, 32'h0000_0055);
    @(posedge clk); #1;
    rready = 1'b0;

    // Reset while the read is waiting for data: no response may follow.
    araddr = 13'h0; arvalid = 1'b1; rready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) break;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rst_mid_strobe_seen", reg_ce, 1'b1);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", outs1(), '0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid) bad++;
    end
    chk("rst_mid_no_rvalid", bad, 0);

    // Both masters pending continuously from reset: write, read, write, read.
    n0 = order_q.size();
    c0 = ce_cnt;
    fork
      begin
        axi_write(13'h0, 32'h11, 4'hF, r1, t1);
        axi_write(13'h4, 32'h22, 4'hF, r2, t2);
      end
      begin
        axi_read(13'h0, d1, r3, t3);
        axi_read(13'h4, d2, r4, t4);
      end
    join
    chk("rr_timeout", {t1, t2, t3, t4}, 4'b0000);
    chk("rr_ce_count", ce_cnt - c0, 4);
    ord = 4'b0000;
    if (order_q.size() >= n0 + 4)
      ord = {order_q[n0], order_q[n0+1], order_q[n0+2], order_q[n0+3]};
    chk("rr_order", ord, 4'b1010);
    chk("rr_resps", {r1, r2, r3, r4}, 8'h00);
    chk("rr_rdata0", d1, 32'h11);
    chk("rr_rdata1", d2, 32'h22);

    axi_read(13'h4, d, resp, to);
    chk("post_rst_read_timeout", to, 1'b0);
    chk("post_rst_read_rdata", d, 32'h22);
    chk("post_rst_read_resp", resp, 2'b00);

    chk("idle_bus_zero_cycles_bad", idle_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
